uart_rx: RTL

UART receiver that recovers frames from the serial line and delivers the 8-bit parallel byte with error flags. It is the receive-side counterpart of the UART transmitter: same frame format (start bit, 8 data bits LSB first, optional parity, one stop bit) and the same `PAR_EN`/`PAR_TYP` configuration. It oversamples `RX_IN` at `Prescale` clocks per bit and takes a 3-sample majority vote at mid-bit. It sits between the pad-side synchronizer and the byte consumer.

---
 rtl/uart_rx.sv | 114 +++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 3-sample mid-bit majority vote, optional parity and stop checking.
//   CLK        : oversampling clock, rising edge
//   RST        : asynchronous active-low reset
//   RX_IN      : serial line, idle high, already synchronized to CLK
//   Prescale   : clocks per bit (8, 16 or 32), latched at start detection
//   PAR_EN     : parity bit present after the data, latched at start detection
//   PAR_TYP    : 0 even / 1 odd parity, latched at start detection
//   P_DATA     : last good byte, held between frames
//   Data_Valid : one-cycle pulse when P_DATA takes a new good byte
//   PAR_ERR    : one-cycle pulse on parity mismatch
//   STP_ERR    : one-cycle pulse when the stop bit is sampled 0
module uart_rx (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] Prescale,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       Data_Valid,
    output logic       PAR_ERR,
    output logic       STP_ERR
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0] r_state;
    logic [5:0] r_edge_cnt;
    logic [2:0] r_bit_cnt;
    logic [2:0] r_smp;
    logic [7:0] r_shift;
    logic [5:0] r_presc;
    logic       r_par_en;
    logic       r_par_typ;
    logic       r_par_bad;

    logic [5:0] w_half;
    logic       w_last;
    logic       w_in_win;
    logic       w_maj;

    assign w_half   = r_presc >> 1;
    assign w_last   = r_edge_cnt == r_presc - 6'd1;
    // Three consecutive samples centred on mid-bit: P/2-1, P/2, P/2+1.
    assign w_in_win = (r_edge_cnt >= w_half - 6'd1) && (r_edge_cnt <= w_half + 6'd1);
    assign w_maj    = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_smp      <= '0;
            r_shift    <= '0;
            r_presc    <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_bad  <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            if (r_state == IDLE) begin
                r_edge_cnt <= '0;
                r_bit_cnt  <= '0;
                if (!RX_IN) begin
                    r_state   <= START;
                    r_presc   <= Prescale;
                    r_par_en  <= PAR_EN;
                    r_par_typ <= PAR_TYP;
                    r_par_bad <= 1'b0;
                end
            end else begin
                r_edge_cnt <= w_last ? 6'd0 : r_edge_cnt + 6'd1;
                if (w_in_win)
                    r_smp <= {r_smp[1:0], RX_IN};
                if (w_last) begin
                    case (r_state)
                        START:
                            r_state <= w_maj ? IDLE : DATA;
                        DATA: begin
                            r_shift   <= {w_maj, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7)
                                r_state <= r_par_en ? PARITY : STOP;
                        end
                        PARITY: begin
                            r_par_bad <= w_maj != (^r_shift ^ r_par_typ);
                            r_state   <= STOP;
                        end
                        STOP: begin
                            STP_ERR <= !w_maj;
                            PAR_ERR <= r_par_bad;
                            if (w_maj && !r_par_bad) begin
                                P_DATA     <= r_shift;
                                Data_Valid <= 1'b1;
                            end
                            r_state <= IDLE;
                        end
                        default:
                            r_state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule
